// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and helpers for the ALU command sequencer.
//   - seq_state_e : sequencer FSM states
//   - SEL_*       : ALU op codes
//   - lat_e       : latency class of an op
//   - sel_to_lat  : maps an op code to its latency class
package alu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitReg,
    StWaitMul,
    StHold
  } seq_state_e;

  localparam logic [2:0] SEL_COPY = 3'd0;
  localparam logic [2:0] SEL_COMP = 3'd1;
  localparam logic [2:0] SEL_AND  = 3'd2;
  localparam logic [2:0] SEL_OR   = 3'd3;
  localparam logic [2:0] SEL_XOR  = 3'd4;
  localparam logic [2:0] SEL_ADD  = 3'd5;
  localparam logic [2:0] SEL_SUB  = 3'd6;
  localparam logic [2:0] SEL_MUL  = 3'd7;

  typedef enum logic [1:0] {
    LatComb,
    LatReg,
    LatMul
  } lat_e;

  // copy/complement pass through an ALU register, multiply is multi-cycle,
  // everything else settles within the issue cycle.
  function automatic lat_e sel_to_lat(input logic [2:0] sel);
    lat_e lat;
    if (sel == SEL_MUL) begin
      lat = LatMul;
    end else if (sel == SEL_COPY || sel == SEL_COMP) begin
      lat = LatReg;
    end else begin
      lat = LatComb;
    end
    return lat;
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: wait/timeout counter for the multiply wait state.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clr_i     : clear counter to zero (priority over en_i)
//   en_i      : count one cycle
//   expired_o : high while enabled in the Limit-th counted cycle
module alu_seq_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q;

  // cnt_q equals the number of enabled cycles already elapsed since clear.
  assign expired_o = en_i && (cnt_q == LastCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the 8-bit ALU. Accepts one op per
// cmd handshake, holds operands on the ALU inputs, waits the op's latency,
// captures the ALU result and offers it on a valid/ready result port.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake; cmd_r1_i, cmd_r2_i, cmd_sel_i
//   alu_r1_o, alu_r2_o, alu_sel_o, alu_mul_start_o : drive the ALU
//   alu_out_i, alu_busy_i   : ALU result and multiplier busy
//   res_valid_o/res_ready_i : result handshake; res_data_o, res_sel_o,
//                             res_zero_o, res_err_o
// Optional: define ALU_MUL_TIMEOUT_EN to abort a multiply whose busy stays
// high for MUL_TIMEOUT wait cycles (res_data all ones, res_err set).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MUL_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [DATA_W-1:0]   cmd_r1_i,
  input  logic [DATA_W-1:0]   cmd_r2_i,
  input  logic [2:0]          cmd_sel_i,
  output logic [DATA_W-1:0]   alu_r1_o,
  output logic [DATA_W-1:0]   alu_r2_o,
  output logic [2:0]          alu_sel_o,
  output logic                alu_mul_start_o,
  input  logic [2*DATA_W-1:0] alu_out_i,
  input  logic                alu_busy_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [2*DATA_W-1:0] res_data_o,
  output logic [2:0]          res_sel_o,
  output logic                res_zero_o,
  output logic                res_err_o
);

  seq_state_e          state_q;
  logic                cmd_ready_q;
  logic [DATA_W-1:0]   alu_r1_q;
  logic [DATA_W-1:0]   alu_r2_q;
  logic [2:0]          alu_sel_q;
  logic                alu_mul_start_q;
  logic                wait_first_q;
  logic                res_valid_q;
  logic [2*DATA_W-1:0] res_data_q;
  logic [2:0]          res_sel_q;
  logic                res_zero_q;
  logic                res_err_q;

  logic capture;
  logic abort;
  logic mul_expired;

`ifdef ALU_MUL_TIMEOUT_EN
  alu_seq_timer #(
    .Limit(MUL_TIMEOUT)
  ) u_mul_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == StIssue),
    .en_i      (state_q == StWaitMul),
    .expired_o (mul_expired)
  );
`else
  logic unused_mul_timeout;
  assign unused_mul_timeout = ^MUL_TIMEOUT;
  assign mul_expired        = 1'b0;
`endif

  // Decide when the ALU output is sampled into the result registers.
  always_comb begin
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIssue:   capture = (sel_to_lat(alu_sel_q) == LatComb);
      StWaitReg: capture = 1'b1;
      StWaitMul: begin
        // First wait cycle ignores busy: the multiplier is still loading.
        capture = !wait_first_q && !alu_busy_i;
        abort   = !capture && mul_expired;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      cmd_ready_q     <= 1'b0;
      alu_r1_q        <= '0;
      alu_r2_q        <= '0;
      alu_sel_q       <= '0;
      alu_mul_start_q <= 1'b0;
      wait_first_q    <= 1'b0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_sel_q       <= '0;
      res_zero_q      <= 1'b0;
      res_err_q       <= 1'b0;
    end else begin
      alu_mul_start_q <= 1'b0;
      wait_first_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid_i) begin
            alu_r1_q        <= cmd_r1_i;
            alu_r2_q        <= cmd_r2_i;
            alu_sel_q       <= cmd_sel_i;
            // Registered so the pulse lands exactly on the issue cycle.
            alu_mul_start_q <= (cmd_sel_i == SEL_MUL);
            cmd_ready_q     <= 1'b0;
            state_q         <= StIssue;
          end
        end
        StIssue: begin
          if (sel_to_lat(alu_sel_q) == LatReg) begin
            state_q <= StWaitReg;
          end else if (sel_to_lat(alu_sel_q) == LatMul) begin
            state_q      <= StWaitMul;
            wait_first_q <= 1'b1;
          end
        end
        StWaitReg: ;
        StWaitMul: ;
        StHold: begin
          if (res_valid_q && res_ready_i) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (capture || abort) begin
        res_valid_q <= 1'b1;
        res_data_q  <= abort ? '1 : alu_out_i;
        res_zero_q  <= !abort && (alu_out_i == '0);
        res_err_q   <= abort;
        res_sel_q   <= alu_sel_q;
        state_q     <= StHold;
      end
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign alu_r1_o        = alu_r1_q;
  assign alu_r2_o        = alu_r2_q;
  assign alu_sel_o       = alu_sel_q;
  assign alu_mul_start_o = alu_mul_start_q;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_sel_o       = res_sel_q;
  assign res_zero_o      = res_zero_q;
  assign res_err_o       = res_err_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command front-end that sits directly upstream of the 8-bit ALU top level and also collects its result.
- Accepts one operation per valid/ready handshake and drives R1/R2/sel into the ALU.
- Waits the latency for that op class: combinational, single-register, or Booth multiply using busy.
- Captures the 16-bit ALU output and presents it downstream on a valid/ready result port with flags.
- Operands are held stable while an op is in flight, so ALU consumers never see mid-op changes.

Parameters:
- DATA_W, 8, operand width; the result is 2*DATA_W.
- MUL_TIMEOUT, 16, maximum WAIT_MUL cycles before abort. Used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_r1  in  DATA_W  operand R1.
- cmd_r2  in  DATA_W  operand R2.
- cmd_sel  in  3  op code: 0 copy, 1 complement, 2 and, 3 or, 4 xor, 5 add, 6 sub, 7 mul.
- alu_r1  out  DATA_W  to ALU R1.
- alu_r2  out  DATA_W  to ALU R2.
- alu_sel  out  3  to ALU sel.
- alu_mul_start  out  1  one-cycle pulse that (re)starts the multiplier.
- alu_out  in  2*DATA_W  ALU result.
- alu_busy  in  1  multiplier busy.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  2*DATA_W  captured result.
- res_sel  out  3  op code of the result.
- res_zero  out  1  res_data == 0.
- res_err  out  1  multiply timeout abort.

Behaviour:
- Reset values: all outputs are 0; state is IDLE.
- rst during any state discards the in-flight op and returns to IDLE the next cycle. No res_valid is produced for that op.
- State IDLE:
  - cmd_ready = 1.
  - On cmd_valid in cycle T, latch r1/r2/sel onto alu_* and go to ISSUE (cycle T+1).
- State ISSUE:
  - Pulse alu_mul_start = 1 for exactly this cycle, only if sel == 7.
  - sel 2..6 (combinational): capture alu_out at the end of T+1. res_valid = 1 at T+2.
  - sel 0..1 (ALU-registered): go to WAIT_REG. Capture at the end of T+2. res_valid = 1 at T+3.
  - sel 7: go to WAIT_MUL.
- State WAIT_MUL:
  - alu_busy is ignored in the first WAIT_MUL cycle, to cover load latency.
  - After that, capture alu_out in the first cycle alu_busy == 0 and go to HOLD. res_valid = 1 the next cycle.
- State HOLD:
  - res_valid = 1; res_data, res_sel, res_zero and res_err are stable.
  - Exit to IDLE only on res_valid & res_ready.
  - cmd_ready = 0 throughout HOLD. Peak throughput is one op per 3 cycles (combinational ops).
- alu_r1, alu_r2 and alu_sel hold their value from ISSUE until HOLD exits. They keep their last value in IDLE.
- Captured data width rules:
  - res_data is the full 16-bit alu_out.
  - add carries in bit 8.
  - sub is 8-bit two's complement, zero-extended.
  - mul is the signed 16-bit product.
- res_zero is computed from the captured value, not live alu_out.
- An illegal or unknown sel cannot occur (3-bit, fully decoded).
- cmd_valid is ignored in every state except IDLE. A command must be held by the source until accepted.

Optional Feature:
ALU_MUL_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT_MUL. If alu_busy is still 1 after MUL_TIMEOUT cycles, go to HOLD with res_data = all ones and res_err = 1. The counter clears on entry to WAIT_MUL and on rst.
- Undefined: no counter. WAIT_MUL waits indefinitely and res_err is tied 0.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum: IDLE, ISSUE, WAIT_REG, WAIT_MUL, HOLD;
  - op code constants SEL_COPY..SEL_MUL;
  - latency class enum: LAT_COMB, LAT_REG, LAT_MUL;
  - function sel_to_lat.
- Sub-module alu_seq_timer: a wait/timeout counter with clear, enable and expiry output. It is instantiated only under the macro.

Test Plan:
- add 0xFF+0x01 accepted at T -> res_valid at T+2, res_data 0x0100, res_zero 0, res_sel 5.
- sub 0x05-0x07 -> res_data 0x00FE at T+2; sub 0x33-0x33 -> res_data 0x0000 with res_zero 1.
- copy 0xA5 -> res_valid at T+3, res_data 0x00A5. cmd_ready stays 0 from T+1 until the HOLD handshake.
- mul 0xFD x 0x04 -> alu_mul_start pulse at T+1 only; result 0xFFF4 after busy falls; alu_r1/alu_r2 stable throughout.
- res_ready low for 5 cycles in HOLD -> res_data stable, cmd_valid ignored. rst asserted mid-WAIT_MUL -> IDLE next cycle, res_valid never rises.
- With ALU_MUL_TIMEOUT_EN, alu_busy stuck at 1 -> after 16 cycles res_valid = 1, res_err = 1, res_data = 0xFFFF.
